// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM states and loss-counter sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    INIT_DELAY = 2'd1,
    RELEASE    = 2'd2,
    RUN        = 2'd3
  } seq_state_e;

  localparam int                    LOST_CNT_W   = 8;
  localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop level synchroniser into i_clk with async active-low clear.
// Output lags input by two edges; no flow control.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_CHANNELS domain resets in index order after a debounced PLL lock; channel 0 falls
// 2+LOCK_FILTER+INITIAL_DELAY+1 edges after reset. Optional RESET_SEQ_LOCK_STATS_EN adds lock_lost_count.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CHANNELS  = 3,
  parameter int CNT_WIDTH     = 16,
  parameter int LOCK_FILTER   = 4,
  parameter int INITIAL_DELAY = 2,
  parameter int STAGE_DELAY   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  input  logic                    sw_reset_req,
  output logic [NUM_CHANNELS-1:0] rst_out,
  output logic                    all_released
`ifdef RESET_SEQ_LOCK_STATS_EN
  ,
  output logic [LOST_CNT_W-1:0]   lock_lost_count
`endif
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] INIT_LD   = CNT_WIDTH'(INITIAL_DELAY);
  localparam logic [CNT_WIDTH-1:0] STAGE_LD  = CNT_WIDTH'(STAGE_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] FILT_LAST = CNT_WIDTH'(LOCK_FILTER - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_CHANNELS - 1);

  generate
    if (NUM_CHANNELS < 1) begin : g_bad_channels
      $error("reset_sequencer: NUM_CHANNELS must be >= 1");
    end
    if (LOCK_FILTER < 1 || (LOCK_FILTER >> CNT_WIDTH) != 0) begin : g_bad_filter
      $error("reset_sequencer: LOCK_FILTER must be >= 1 and fit in CNT_WIDTH");
    end
    if (INITIAL_DELAY < 0 || (INITIAL_DELAY >> CNT_WIDTH) != 0) begin : g_bad_init
      $error("reset_sequencer: INITIAL_DELAY must be >= 0 and fit in CNT_WIDTH");
    end
    if (STAGE_DELAY < 1 || (STAGE_DELAY >> CNT_WIDTH) != 0) begin : g_bad_stage
      $error("reset_sequencer: STAGE_DELAY must be >= 1 and fit in CNT_WIDTH");
    end
  endgenerate

  logic                    w_lock_s;
  logic                    w_lost;
  seq_state_e              r_state;
  logic [CNT_WIDTH-1:0]    r_filter;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_CHANNELS-1:0] r_rst_out;
  logic                    r_all_released;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  // A loss event is only counted once the lock has been qualified.
  assign w_lost = (r_state != WAIT_LOCK) && !w_lock_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= WAIT_LOCK;
      r_filter       <= '0;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_rst_out      <= '1;
      r_all_released <= 1'b0;
    end else if (w_lost) begin
      r_state        <= WAIT_LOCK;
      r_filter       <= '0;
      r_rst_out      <= '1;
      r_all_released <= 1'b0;
    end else if (sw_reset_req && (r_state != WAIT_LOCK)) begin
      r_state        <= INIT_DELAY;
      r_cnt          <= INIT_LD;
      r_rst_out      <= '1;
      r_all_released <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (!w_lock_s) begin
            r_filter <= '0;
          end else begin
            r_filter <= r_filter + CNT_ONE;
            if (r_filter == FILT_LAST) begin
              r_state <= INIT_DELAY;
              r_cnt   <= INIT_LD;
            end
          end
        end
        INIT_DELAY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_rst_out[0] <= 1'b0;
            if (NUM_CHANNELS == 1) begin
              r_state        <= RUN;
              r_all_released <= 1'b1;
            end else begin
              r_state <= RELEASE;
              r_idx   <= IDX_ONE;
              r_cnt   <= STAGE_LD;
            end
          end
        end
        RELEASE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_rst_out[r_idx] <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state        <= RUN;
              r_all_released <= 1'b1;
            end else begin
              r_idx <= r_idx + IDX_ONE;
              r_cnt <= STAGE_LD;
            end
          end
        end
        RUN: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign rst_out      = r_rst_out;
  assign all_released = r_all_released;

`ifdef RESET_SEQ_LOCK_STATS_EN
  logic [LOST_CNT_W-1:0] r_lost_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lost_cnt <= '0;
    end else if (w_lost && (r_lost_cnt != LOST_CNT_MAX)) begin
      r_lost_cnt <= r_lost_cnt + LOST_CNT_W'(1);
    end
  end

  assign lock_lost_count = r_lost_cnt;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; edges counted from reset_n release.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic [2:0] rst_out;
  logic       all_released;
`ifdef RESET_SEQ_LOCK_STATS_EN
  logic [7:0] lock_lost_count;
`endif

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CHANNELS  (3),
    .CNT_WIDTH     (16),
    .LOCK_FILTER   (4),
    .INITIAL_DELAY (2),
    .STAGE_DELAY   (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .sw_reset_req    (sw_reset_req),
    .rst_out         (rst_out),
    .all_released    (all_released)
`ifdef RESET_SEQ_LOCK_STATS_EN
    ,
    .lock_lost_count (lock_lost_count)
`endif
  );

  // Outputs are sampled 2 time units after each rising edge; inputs change at the same point.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      edge_n++;
    end
  endtask

  task automatic do_reset(input logic lock);
    reset_n      = 1'b0;
    pll_locked   = lock;
    sw_reset_req = 1'b0;
    step(2);
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  task automatic measure(input int n, output int f0, output int f1, output int f2, output int fa);
    f0 = -1; f1 = -1; f2 = -1; fa = -1;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (f0 < 0 && rst_out[0] === 1'b0) f0 = edge_n;
      if (f1 < 0 && rst_out[1] === 1'b0) f1 = edge_n;
      if (f2 < 0 && rst_out[2] === 1'b0) f2 = edge_n;
      if (fa < 0 && all_released === 1'b1) fa = edge_n;
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    pll_locked   = 1'b1;
    sw_reset_req = 1'b0;
    step(2);
    checks++;
    if (rst_out !== 3'b111) begin
      failures++; $display("FAIL reset_rst_out got=%b exp=111", rst_out);
    end
    checks++;
    if (all_released !== 1'b0) begin
      failures++; $display("FAIL reset_all_released got=%b exp=0", all_released);
    end
`ifdef RESET_SEQ_LOCK_STATS_EN
    checks++;
    if (lock_lost_count !== 8'd0) begin
      failures++; $display("FAIL reset_lost_count got=%0d exp=0", lock_lost_count);
    end
`endif
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  task automatic test_nominal();
    int f0, f1, f2, fa;
    measure(40, f0, f1, f2, fa);
    checks++;
    if (f0 !== 9) begin failures++; $display("FAIL nominal_ch0_edge got=%0d exp=9", f0); end
    checks++;
    if (f1 !== 17) begin failures++; $display("FAIL nominal_ch1_edge got=%0d exp=17", f1); end
    checks++;
    if (f2 !== 25) begin failures++; $display("FAIL nominal_ch2_edge got=%0d exp=25", f2); end
    checks++;
    if (fa !== 25) begin failures++; $display("FAIL nominal_all_rel_edge got=%0d exp=25", fa); end
    checks++;
    if (rst_out !== 3'b000) begin failures++; $display("FAIL nominal_run_rst got=%b exp=000", rst_out); end
  endtask

  task automatic test_sw_reset();
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    checks++;
    if (rst_out !== 3'b111 || all_released !== 1'b0) begin
      failures++; $display("FAIL sw_reassert got=%b/%b exp=111/0", rst_out, all_released);
    end
    step(2);
    checks++;
    if (rst_out !== 3'b111) begin failures++; $display("FAIL sw_hold got=%b exp=111", rst_out); end
    step(1);
    checks++;
    if (rst_out !== 3'b110) begin failures++; $display("FAIL sw_ch0_release got=%b exp=110", rst_out); end
`ifdef RESET_SEQ_LOCK_STATS_EN
    checks++;
    if (lock_lost_count !== 8'd0) begin
      failures++; $display("FAIL sw_lost_count got=%0d exp=0", lock_lost_count);
    end
`endif
    step(8);
    checks++;
    if (rst_out !== 3'b100) begin failures++; $display("FAIL sw_ch1_release got=%b exp=100", rst_out); end
    step(8);
    checks++;
    if (rst_out !== 3'b000 || all_released !== 1'b1) begin
      failures++; $display("FAIL sw_all_release got=%b/%b exp=000/1", rst_out, all_released);
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    step(2);
    checks++;
    if (rst_out !== 3'b000 || all_released !== 1'b1) begin
      failures++; $display("FAIL loss_sync_delay got=%b/%b exp=000/1", rst_out, all_released);
    end
    pll_locked = 1'b1;
    step(1);
    checks++;
    if (rst_out !== 3'b111 || all_released !== 1'b0) begin
      failures++; $display("FAIL loss_reassert got=%b/%b exp=111/0", rst_out, all_released);
    end
`ifdef RESET_SEQ_LOCK_STATS_EN
    checks++;
    if (lock_lost_count !== 8'd1) begin
      failures++; $display("FAIL loss_count got=%0d exp=1", lock_lost_count);
    end
`endif
    step(7);
    checks++;
    if (rst_out !== 3'b111) begin failures++; $display("FAIL loss_requalify got=%b exp=111", rst_out); end
    step(1);
    checks++;
    if (rst_out !== 3'b110) begin failures++; $display("FAIL loss_ch0 got=%b exp=110", rst_out); end
    step(8);
    checks++;
    if (rst_out !== 3'b100) begin failures++; $display("FAIL loss_ch1 got=%b exp=100", rst_out); end
    step(8);
    checks++;
    if (rst_out !== 3'b000 || all_released !== 1'b1) begin
      failures++; $display("FAIL loss_all got=%b/%b exp=000/1", rst_out, all_released);
    end
  endtask

  // sw_reset_req is held high throughout WAIT_LOCK to show it has no effect there.
  task automatic test_lock_glitch();
    do_reset(1'b1);
    sw_reset_req = 1'b1;
    step(3);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(5);
    checks++;
    if (rst_out !== 3'b111 || all_released !== 1'b0) begin
      failures++; $display("FAIL glitch_no_release got=%b/%b exp=111/0", rst_out, all_released);
    end
    sw_reset_req = 1'b0;
    step(3);
    checks++;
    if (rst_out !== 3'b111) begin failures++; $display("FAIL glitch_edge12 got=%b exp=111", rst_out); end
    step(1);
    checks++;
    if (rst_out !== 3'b110) begin failures++; $display("FAIL glitch_edge13 got=%b exp=110", rst_out); end
  endtask

  task automatic test_reset_mid_release();
    int f0, f1, f2, fa;
    do_reset(1'b1);
    step(12);
    checks++;
    if (rst_out !== 3'b110) begin failures++; $display("FAIL midrel_state got=%b exp=110", rst_out); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (rst_out !== 3'b111 || all_released !== 1'b0) begin
      failures++; $display("FAIL midrel_async got=%b/%b exp=111/0", rst_out, all_released);
    end
    step(1);
    reset_n = 1'b1;
    edge_n  = 0;
    measure(30, f0, f1, f2, fa);
    checks++;
    if (f0 !== 9) begin failures++; $display("FAIL midrel_restart_ch0 got=%0d exp=9", f0); end
    checks++;
    if (fa !== 25) begin failures++; $display("FAIL midrel_restart_all got=%0d exp=25", fa); end
  endtask

`ifdef RESET_SEQ_LOCK_STATS_EN
  // Each iteration qualifies lock, then drops it once the FSM has left WAIT_LOCK.
  task automatic lose_lock(input int n);
    for (int i = 0; i < n; i++) begin
      pll_locked = 1'b1;
      step(7);
      pll_locked = 1'b0;
      step(4);
    end
  endtask

  task automatic test_lock_stats();
    do_reset(1'b0);
    lose_lock(254);
    checks++;
    if (lock_lost_count !== 8'd254) begin
      failures++; $display("FAIL stats_254 got=%0d exp=254", lock_lost_count);
    end
    lose_lock(46);
    checks++;
    if (lock_lost_count !== 8'd255) begin
      failures++; $display("FAIL stats_saturate got=%0d exp=255", lock_lost_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_sw_reset();
    test_lock_loss();
    test_lock_glitch();
    test_reset_mid_release();
`ifdef RESET_SEQ_LOCK_STATS_EN
    test_lock_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output power-on reset.
- Waits for a debounced PLL lock, then releases NUM_CHANNELS per-domain resets in index order (channel 0 first), with a programmable gap between channels.
- Re-asserts every domain reset when lock is lost or software requests it.
- Sits between the clock/PLL block and the LPC sniffer, UART and FIFO domains.

Parameters:
- NUM_CHANNELS, 3: number of reset outputs; must be >= 1.
- CNT_WIDTH, 16: width of the delay counters; every delay parameter must fit.
- LOCK_FILTER, 4: consecutive synchronised lock-high cycles needed to qualify lock; must be >= 1.
- INITIAL_DELAY, 2: cycles from lock qualification to channel 0 release.
- STAGE_DELAY, 8: cycles between channel k-1 release and channel k release; must be >= 1.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- pll_locked, in, 1: PLL lock, asynchronous to clk; double-flop synchronised internally.
- sw_reset_req, in, 1: synchronous request to restart the release sequence.
- rst_out, out, NUM_CHANNELS: active-high domain resets.
- all_released, out, 1: high once every rst_out bit is low.
- lock_lost_count, out, 8: present only with the optional feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Values while reset_n is low:
  - rst_out = all ones; all_released = 0; lock_lost_count = 0.
  - Synchroniser flops = 0; lock filter = 0; delay counter = 0; channel index = 0; state = WAIT_LOCK.
- Lock synchronisation: pll_locked passes through a 2-flop synchroniser; its output is lock_s.
- WAIT_LOCK:
  - The filter counter increments on each edge with lock_s = 1 and clears on any edge with lock_s = 0.
  - On the edge where the filter reaches LOCK_FILTER: go to INIT_DELAY and load cnt = INITIAL_DELAY.
- INIT_DELAY:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, clear rst_out[0] on this edge, then:
    - if NUM_CHANNELS == 1: go to RUN and set all_released;
    - otherwise: go to RELEASE with idx = 1 and cnt = STAGE_DELAY - 1.
- RELEASE:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, clear rst_out[idx], then:
    - if idx == NUM_CHANNELS - 1: go to RUN and set all_released on the same edge;
    - otherwise: idx + 1 and cnt = STAGE_DELAY - 1.
- Release timing: channel k falls exactly STAGE_DELAY edges after channel k-1.
- RUN: hold all outputs.
- Released channels never re-assert individually; re-assertion is always all channels at once.
- Lock loss (lock_s = 0 in INIT_DELAY, RELEASE or RUN):
  - On the next edge: rst_out = all ones, all_released = 0, filter = 0, go to WAIT_LOCK.
  - Counts as one loss event.
- sw_reset_req = 1 in INIT_DELAY, RELEASE or RUN with lock_s = 1:
  - On the next edge: rst_out = all ones, all_released = 0, go to INIT_DELAY with cnt = INITIAL_DELAY.
  - Lock is not re-qualified.
  - In WAIT_LOCK, sw_reset_req is ignored.
- Priority when events coincide: reset_n, then lock loss, then sw_reset_req, then normal sequencing.
- Latency: with pll_locked already high at reset release, rst_out[0] falls on edge 2 + LOCK_FILTER + INITIAL_DELAY + 1.
- Arithmetic: all counters are unsigned; none wrap.
- Parameter checks: an illegal parameter triggers an elaboration-time error (generate-time check).

Optional Feature:
- Macro: RESET_SEQ_LOCK_STATS_EN.
- With the macro defined:
  - The lock_lost_count port exists.
  - It is an 8-bit counter that increments once per lock-loss event and saturates at 255.
  - Only reset_n clears it; sw_reset_req does not.
- Without the macro: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package reset_seq_pkg holds:
  - the state enum (WAIT_LOCK, INIT_DELAY, RELEASE, RUN);
  - the localparam LOST_CNT_W = 8;
  - the saturation constant 8'hFF.
- Sub-module sync_2ff: a generic 2-flop synchroniser with asynchronous active-low clear, used for pll_locked.

Test Plan (default parameters; edges counted from the first clk edge after reset_n rises):
- Nominal: pll_locked = 1 throughout -> rst_out[0] falls at edge 9, rst_out[1] at edge 17, rst_out[2] at edge 25; all_released = 1 from edge 25.
- Lock glitch: pll_locked high for 3 synchronised cycles, low 1 cycle, then stable high -> no release during the glitch; the filter restarts; rst_out[0] falls 4 + 2 + 1 edges after lock_s returns high.
- Lock loss in RUN: pll_locked low for 2 cycles -> rst_out = 3'b111 and all_released = 0 within 3 edges; lock_lost_count = 1; the full sequence (filter, initial delay, stages) repeats.
- sw_reset_req 1-cycle pulse in RUN -> rst_out = 3'b111 on the next edge; rst_out[0] falls 3 edges later; lock_lost_count unchanged.
- reset_n low mid-RELEASE (rst_out = 3'b110) -> rst_out = 3'b111 and all_released = 0 immediately, with no clk edge; the state restarts in WAIT_LOCK.
- With RESET_SEQ_LOCK_STATS_EN: 300 lock-loss events -> lock_lost_count = 255 and holds there.
